// File: rtl/aes_pkg.sv
// Shared AES constants, S-box mode type and GF(2^8) helper functions.
package aes_pkg;

    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;
    localparam logic [8:0] GF_POLY      = 9'h11B;

    typedef enum logic {
        SBOX_FWD = 1'b0,
        SBOX_INV = 1'b1
    } sbox_mode_t;

    // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1 on every shift.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (GF_POLY[7:0] & {8{aa[7]}});
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; 0 maps to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        t = x;                                  // x^1
        for (int i = 0; i < 6; i++) begin
            t = gf_mul(gf_mul(t, t), x);        // x^3, x^7, ... x^127
        end
        return gf_mul(t, t);                    // x^254
    endfunction

    // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ AFFINE_C;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] affine_inv(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte forward/inverse AES S-box, purely combinational.
// One GF inverter is shared by both directions: the inverse affine is applied
// before it for decrypt, the forward affine after it for encrypt.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0]  din,
    input  sbox_mode_t  mode,
    output logic [7:0]  dout
);

    logic [7:0] inv_in;
    logic [7:0] inv_out;

    // Route through the shared inverter according to direction.
    always_comb begin
        inv_in  = (mode == SBOX_INV) ? affine_inv(din) : din;
        inv_out = gf_inv(inv_in);
        dout    = (mode == SBOX_INV) ? inv_out : affine_fwd(inv_out);
    end

endmodule

// File: rtl/sbox_lane_pipe.sv
// LANES-wide pipelined AES byte substitution with valid/ready flow control.
// Stage 1 optionally captures the input beat, stage 2 holds the substituted
// result. in_ready is combinational from out_ready (no skid buffer).
module sbox_lane_pipe
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter bit REG_IN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mode,
    output logic [8*LANES-1:0] out_data
);

    localparam int W = 8 * LANES;

    logic         v1, m1;
    logic [W-1:0] d1;
    logic         v2, m2;
    logic [W-1:0] d2;
    logic [W-1:0] sub;
    logic         adv2;

    assign adv2 = !v2 || out_ready;

    generate
        if (REG_IN) begin : g_reg_in
            logic         v1_q, m1_q;
            logic [W-1:0] d1_q;

            assign in_ready = !v1_q || adv2;

            // Stage-1 capture; data/mode only sampled on a real beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v1_q <= 1'b0;
                    m1_q <= 1'b0;
                    d1_q <= '0;
                end else if (in_ready) begin
                    v1_q <= in_valid;
                    if (in_valid) begin
                        d1_q <= in_data;
                        m1_q <= in_mode;
                    end
                end
            end

            assign v1 = v1_q;
            assign m1 = m1_q;
            assign d1 = d1_q;
        end else begin : g_bypass
            assign in_ready = adv2;
            assign v1       = in_valid;
            assign m1       = in_mode;
            assign d1       = in_data;
        end
    endgenerate

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_byte u_sbox (
            .din  (d1[8*i +: 8]),
            .mode (sbox_mode_t'(m1)),
            .dout (sub[8*i +: 8])
        );
    end

    // Stage-2 output register; holds its beat while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            m2 <= 1'b0;
            d2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                d2 <= sub;
                m2 <= m1;
            end
        end
    end

    assign out_valid = v2;
    assign out_mode  = m2;
    assign out_data  = d2;

endmodule
